// File: rtl/data_mem_interface_pkg.sv
// Shared definitions for the data-memory access stage.
//   state_t       - access FSM states
//   LINE_BYTES    - bytes per RAM line
//   MASK_W        - width of the active-low byte mask
//   mask_to_size  - access size in bytes from the byte mask
package data_mem_interface_pkg;

    localparam int LINE_BYTES = 16;
    localparam int MASK_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RESP,
        ERR
    } state_t;

    // Access size = number of contiguous zero bits starting at mask bit 0.
    // Bits above the first one are ignored.
    function automatic logic [4:0] mask_to_size(input logic [MASK_W-1:0] mask);
        logic [4:0] n;
        logic       run;
        // NOTE: blocking assignments are correct here; this is pure
        // combinational evaluation inside a function, not clocked state.
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < MASK_W; i++) begin
            if (run && !mask[i]) n = n + 5'd1;
            else                 run = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/data_mem_interface_byte_lane_merge.sv
// Combinational byte-lane merge for the store read-modify-write.
//   line    in   128  current RAM line
//   word    in   32   store data, byte 0 in [7:0]
//   offset  in   4    first byte lane in the line to replace
//   size    in   5    number of bytes to replace (only word bytes 0..3 exist)
//   merged  out  128  line with lanes offset..offset+size-1 replaced
module byte_lane_merge
    import data_mem_interface_pkg::*;
(
    input  logic [8*LINE_BYTES-1:0] line,
    input  logic [31:0]             word,
    input  logic [3:0]              offset,
    input  logic [4:0]              size,
    output logic [8*LINE_BYTES-1:0] merged
);

    always_comb begin
        // NOTE: default assignment first so every path drives merged and
        // no latch is inferred.
        merged = line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i == int'(offset) + k && k < int'(size))
                    merged[8*i +: 8] = word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_interface.sv
// Data-memory access stage behind the load/store controller.
// Performs a line read (load) or read-modify-write (store) on a 128-bit
// single-port synchronous RAM, returning the byte-aligned 32-bit load word.
// Line-crossing and out-of-range requests are rejected without touching RAM.
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_wr/addr/wdata/wr_mask request: store flag, byte address, data, mask
//   resp_valid/rdata/err      one-cycle response pulse
//   mem_en/we/addr/wdata      RAM command; mem_rdata valid cycle after read
module data_mem_interface
    import data_mem_interface_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [MASK_W-1:0]       req_wr_mask,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic [8*LINE_BYTES-1:0] mem_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] line_q;
    logic [3:0]        off_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic [4:0]        size_q;

    logic [4:0]        req_size;
    logic [4:0]        eff_size;
    logic              req_bad;
    logic              accept;
    logic              write_now;
    logic [31:0]       load_word;

    // Request check, evaluated on the live request so the error can be
    // reported one cycle after accept.
    always_comb begin
        req_size = mask_to_size(req_wr_mask);
        // An all-ones mask means a full word for loads.
        eff_size = (req_size == 5'd0 && !req_wr) ? 5'd4 : req_size;
        req_bad  = (({2'b00, req_addr[3:0]} + {1'b0, eff_size}) > 6'd16)
                 | (|req_addr[31:ADDR_W+4]);
    end

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= req_bad ? ERR : RD;
                RD:      state <= RESP;
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: request registers carry no reset; they are only consumed after
    // an accept has loaded them, so resetting them would add logic for nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q  <= req_addr[ADDR_W+3:4];
            off_q   <= req_addr[3:0];
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            size_q  <= eff_size;
        end
    end

    // Load word: line shifted down by the byte offset, zero beyond the line.
    always_comb begin
        load_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(off_q) + k < LINE_BYTES)
                load_word[8*k +: 8] = mem_rdata[8*(int'(off_q) + k) +: 8];
        end
    end

    byte_lane_merge u_merge (
        .line   (mem_rdata),
        .word   (wdata_q),
        .offset (off_q),
        .size   (size_q),
        .merged (mem_wdata)
    );

    // Outputs decode the state and are gated by rst so a reset in RESP
    // suppresses both the response and a pending RMW write immediately.
    assign write_now  = !rst && (state == RESP) && wr_q && (size_q != 5'd0);
    assign mem_en     = (!rst && (state == RD)) || write_now;
    assign mem_we     = write_now;
    assign mem_addr   = line_q;
    assign resp_valid = !rst && ((state == RESP) || (state == ERR));
    assign resp_err   = !rst && (state == ERR);
    assign resp_rdata = (!rst && (state == RESP) && !wr_q) ? load_word : 32'd0;

endmodule
